dual_trigger_window_counter: RTL
================================

Name: dual_trigger_window_counter

Overview:
Receiving end of the periodic dual-trigger scheme. It counts single-cycle trigger pulses on two independent channels over a fixed measurement window. At the end of the window it reports both counts and then signals completion with a done pulse plus a sticky done flag. It sits beside the trigger generators and gives the sequencer or checker one completion event to wait on.

Parameters:
WINDOW  200  window length in clock cycles (number of edges on which triggers are sampled); >= 2
CNT_W   8    width of each trigger counter and result

Ports:
clk         input   1      rising-edge clock
rst         input   1      asynchronous reset, active-high
start       input   1      begin a measurement window; sampled only in IDLE
trig1       input   1      channel 1 trigger; one count per high cycle
trig2       input   1      channel 2 trigger; one count per high cycle
busy        output  1      high from the window start through the DONE cycle
cnt1_o      output  CNT_W  latched channel 1 result
cnt2_o      output  CNT_W  latched channel 2 result
res_valid   output  1      one-cycle strobe when cnt1_o/cnt2_o update
done        output  1      one-cycle completion pulse, one cycle after res_valid
done_seen   output  1      sticky done; set with done, cleared by accepted start or rst
sat1, sat2  output  1      sticky saturation flag per channel for the last window

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high. While rst is high:
  - state = IDLE;
  - all counters, cnt1_o, cnt2_o, res_valid, done, done_seen, sat1, sat2 and busy are 0.
- FSM states: IDLE, COUNT, REPORT, DONE.
- IDLE:
  - start=1 at edge E: go to COUNT, clear the internal counters, window timer, done_seen, sat1 and sat2; busy=1 after E.
  - start=0: remain in IDLE.
  - cnt1_o/cnt2_o keep their last values.
- COUNT:
  - The trig inputs are sampled on edges E+1 .. E+WINDOW inclusive, exactly WINDOW samples.
  - Each sampled high trig increments its counter by 1.
  - trig1 and trig2 are fully independent; both high in the same cycle increments both.
  - A trigger on the last sampled edge (E+WINDOW) is counted.
  - Triggers at edge E (the start edge) are not counted.
- Saturation: a counter at 2^CNT_W-1 holds its value. A sampled trigger while it is saturated sets the matching satN flag.
- Window timer: counts 0 .. WINDOW-1. After edge E+WINDOW the state becomes REPORT.
- REPORT (one cycle):
  - At edge E+WINDOW+1: cnt1_o/cnt2_o load the final counts and res_valid is high for that cycle only.
  - Go to DONE.
- DONE (one cycle):
  - At edge E+WINDOW+2: done is high for one cycle and done_seen sets.
  - Go to IDLE; busy drops after this cycle.
- start outside IDLE is ignored: no restart, no error, no effect on the counts.
- start held high continuously: a new window begins on the first IDLE edge after DONE. done_seen is then cleared on that edge.
- Trigger inputs outside COUNT are ignored.
- rst asserted mid-window: the window is aborted immediately.
  - No res_valid or done is produced.
  - Outputs take their reset values, and cnt1_o/cnt2_o read 0.
- Latency from the start edge:
  - res_valid at E+WINDOW+1;
  - done at E+WINDOW+2;
  - earliest next accepted start at E+WINDOW+3.
- Widths: the window timer is $clog2(WINDOW) bits. All counter arithmetic is unsigned, with no wrap.

Test Plan:
- Nominal: WINDOW=200; start at edge 0; trig1 high on edges 1,21,...,181; trig2 on edges 1,41,...,161 -> res_valid at edge 201 with cnt1_o=10, cnt2_o=5; done at edge 202; done_seen=1 afterward.
- Window boundaries: single trig1 pulses on edges 0, 200 and 201 relative to start -> cnt1_o=1 (only edge 200 counted).
- Simultaneous and saturation: CNT_W=4, trig1 and trig2 both high for all 200 cycles -> cnt1_o=cnt2_o=15, sat1=sat2=1.
- Restart handling: start pulsed mid-COUNT and again during DONE -> both ignored, single done. Then start held high -> second window accepted at edge E+WINDOW+3, done_seen cleared on that edge.
- Reset mid-window: rst at cycle 100 -> no res_valid or done; all outputs 0. A fresh window after rst releases yields correct counts.
- Idle isolation: triggers toggled in IDLE with no start -> counts, res_valid and done stay 0 and busy=0.

Source files
------------

// File: rtl/dual_trigger_window_counter.sv
// Dual-channel trigger counter over a fixed measurement window.
// Reports both counts, then a done pulse and a sticky done flag.
module dual_trigger_window_counter #(
    parameter int WINDOW = 200,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             trig1,
    input  logic             trig2,
    output logic             busy,
    output logic [CNT_W-1:0] cnt1_o,
    output logic [CNT_W-1:0] cnt2_o,
    output logic             res_valid,
    output logic             done,
    output logic             done_seen,
    output logic             sat1,
    output logic             sat2
);

    localparam int TW = $clog2(WINDOW);
    localparam logic [TW-1:0] T_LAST = TW'(WINDOW - 1);
    localparam logic [CNT_W-1:0] C_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        REPORT,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [TW-1:0]    timer;
    logic [CNT_W-1:0] cnt1;
    logic [CNT_W-1:0] cnt2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = COUNT;
            COUNT:   if (timer == T_LAST) state_nx = REPORT;
            REPORT:  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Counters hold at full scale; a trigger while full marks saturation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer     <= '0;
            cnt1      <= '0;
            cnt2      <= '0;
            cnt1_o    <= '0;
            cnt2_o    <= '0;
            res_valid <= 1'b0;
            done      <= 1'b0;
            done_seen <= 1'b0;
            sat1      <= 1'b0;
            sat2      <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        timer     <= '0;
                        cnt1      <= '0;
                        cnt2      <= '0;
                        done_seen <= 1'b0;
                        sat1      <= 1'b0;
                        sat2      <= 1'b0;
                    end
                end
                COUNT: begin
                    timer <= timer + 1'b1;
                    if (trig1) begin
                        if (cnt1 == C_MAX) sat1 <= 1'b1;
                        else cnt1 <= cnt1 + 1'b1;
                    end
                    if (trig2) begin
                        if (cnt2 == C_MAX) sat2 <= 1'b1;
                        else cnt2 <= cnt2 + 1'b1;
                    end
                end
                REPORT: begin
                    cnt1_o    <= cnt1;
                    cnt2_o    <= cnt2;
                    res_valid <= 1'b1;
                end
                DONE: begin
                    done      <= 1'b1;
                    done_seen <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
